// File: rtl/submatrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module : submatrix_pkg
//  Brief  : Shared FSM state encoding and width helper for the submatrix
//           window generator.
//  Rev    : 1.0  initial release
// ============================================================================
package submatrix_pkg;

  // Frame sequencer states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bits needed to index 'value' items, never less than one so that
  // degenerate sizes still produce a legal vector.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/submatrix_window_gen_tile_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module : tile_addr_counter
//  Brief  : Nested tile-row / tile-column / row / column counters that walk
//           a row-major image one tile at a time and form the ROM address.
//  Rev    : 1.0  initial release
// ============================================================================
module tile_addr_counter
  import submatrix_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int WIN    = 4,
  parameter int ADDR_W = 16
) (
  input  logic                                clock,
  input  logic                                resetN,
  input  logic                                clear,
  input  logic                                advance,
  output logic [ADDR_W-1:0]                   addr,
  output logic [ADDR_W-1:0]                   tile_r,
  output logic [ADDR_W-1:0]                   tile_c,
  output logic [clog2_min1(WIN*WIN)-1:0]      elem,
  output logic                                first_elem,
  output logic                                last_elem,
  output logic                                last_tile
);

  localparam int RC_W = clog2_min1(WIN);
  localparam int KW   = clog2_min1(WIN*WIN);

  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(WIN - 1);
  localparam logic [KW-1:0]     ELEM_LAST = KW'(WIN*WIN - 1);
  localparam logic [ADDR_W-1:0] TC_LAST   = ADDR_W'(IMG_W/WIN - 1);
  localparam logic [ADDR_W-1:0] TR_LAST   = ADDR_W'(IMG_H/WIN - 1);

  logic [RC_W-1:0]   c_q, c_d, r_q, r_d;
  logic [ADDR_W-1:0] tc_q, tc_d, tr_q, tr_d;
  logic [KW-1:0]     elem_q, elem_d;
  logic [ADDR_W-1:0] pix_row;

  // Step column, then row, then tile column, then tile row; all wrap to zero
  // after the last tile so the next frame starts clean.
  always_comb begin
    c_d    = c_q;
    r_d    = r_q;
    tc_d   = tc_q;
    tr_d   = tr_q;
    elem_d = elem_q;
    if (clear) begin
      c_d    = '0;
      r_d    = '0;
      tc_d   = '0;
      tr_d   = '0;
      elem_d = '0;
    end else if (advance) begin
      elem_d = (elem_q == ELEM_LAST) ? '0 : elem_q + 1'b1;
      if (c_q == RC_LAST) begin
        c_d = '0;
        if (r_q == RC_LAST) begin
          r_d = '0;
          if (tc_q == TC_LAST) begin
            tc_d = '0;
            tr_d = (tr_q == TR_LAST) ? '0 : tr_q + 1'b1;
          end else begin
            tc_d = tc_q + 1'b1;
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      c_q    <= '0;
      r_q    <= '0;
      tc_q   <= '0;
      tr_q   <= '0;
      elem_q <= '0;
    end else begin
      c_q    <= c_d;
      r_q    <= r_d;
      tc_q   <= tc_d;
      tr_q   <= tr_d;
      elem_q <= elem_d;
    end
  end

  // Pixel address (tr*WIN + r)*IMG_W + tc*WIN + c; the parameter check in
  // the top guarantees it fits ADDR_W.
  assign pix_row    = tr_q * ADDR_W'(WIN) + ADDR_W'(r_q);
  assign addr       = pix_row * ADDR_W'(IMG_W) + tc_q * ADDR_W'(WIN) + ADDR_W'(c_q);
  assign tile_r     = tr_q;
  assign tile_c     = tc_q;
  assign elem       = elem_q;
  assign first_elem = (elem_q == '0);
  assign last_elem  = (elem_q == ELEM_LAST);
  assign last_tile  = (tr_q == TR_LAST) && (tc_q == TC_LAST);

endmodule
`default_nettype wire

// File: rtl/submatrix_window_gen.sv
`default_nettype none
// ============================================================================
//  Module : submatrix_window_gen
//  Brief  : Streams WIN x WIN tiles of a row-major image out of a one-cycle
//           latency ROM; fill register plus output register let the next
//           tile be fetched while the current one waits on win_ready.
//           Define SUBMATRIX_DEBUG_EN to expose dbg_state / dbg_elem.
//  Rev    : 1.0  initial release
// ============================================================================
module submatrix_window_gen
  import submatrix_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int WIN    = 4,
  parameter int PIX_W  = 1,
  parameter int ADDR_W = 16
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          start,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_rd,
  input  logic [PIX_W-1:0]              mem_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [WIN*WIN*PIX_W-1:0]      win_data,
  output logic [ADDR_W-1:0]             win_tile_r,
  output logic [ADDR_W-1:0]             win_tile_c,
  output logic                          busy,
  output logic                          done
`ifdef SUBMATRIX_DEBUG_EN
  ,
  output logic [2:0]                    dbg_state,
  output logic [clog2_min1(WIN*WIN)-1:0] dbg_elem
`endif
);

  localparam int KW = clog2_min1(WIN*WIN);
  localparam int DW = WIN*WIN*PIX_W;

  // Reject geometries the address counter cannot walk exactly.
  if ((IMG_W % WIN) != 0 || (IMG_H % WIN) != 0) begin : g_bad_dims
    $error("submatrix_window_gen: IMG_W and IMG_H must be multiples of WIN");
  end
  if ((64'(IMG_W) * 64'(IMG_H)) > (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("submatrix_window_gen: image does not fit in ADDR_W address bits");
  end

  state_t            state_q, state_d;

  logic [ADDR_W-1:0] cnt_addr, cnt_tr, cnt_tc;
  logic [KW-1:0]     cnt_elem;
  logic              cnt_first, cnt_last_elem, cnt_last_tile, cnt_clear;

  logic              issue_ok, rd_en, accept, cap_last;

  logic              rd_pend_q, rd_pend_d, pend_last_q, pend_last_d;
  logic [KW-1:0]     pend_elem_q, pend_elem_d;
  logic [ADDR_W-1:0] pend_tr_q, pend_tr_d, pend_tc_q, pend_tc_d;

  logic [DW-1:0]     fill_word;
  logic [DW-1:0]     fill_q, fill_d;
  logic              fill_full_q, fill_full_d;
  logic [ADDR_W-1:0] fill_tr_q, fill_tr_d, fill_tc_q, fill_tc_d;

  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_tr_q, out_tr_d, out_tc_q, out_tc_d;

  tile_addr_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .WIN    (WIN),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clock      (clock),
    .resetN     (resetN),
    .clear      (cnt_clear),
    .advance    (rd_en),
    .addr       (cnt_addr),
    .tile_r     (cnt_tr),
    .tile_c     (cnt_tc),
    .elem       (cnt_elem),
    .first_elem (cnt_first),
    .last_elem  (cnt_last_elem),
    .last_tile  (cnt_last_tile)
  );

  // Read issue: a new tile may only start when the tile completing in this
  // cycle is guaranteed a home in the output register (win_ready -> mem_rd).
  always_comb begin
    issue_ok    = !out_valid_q || win_ready;
    rd_en       = (state_q == S_FETCH) && (!cnt_first || issue_ok);
    cnt_clear   = (state_q == S_IDLE) && start;
    accept      = out_valid_q && win_ready;
    rd_pend_d   = rd_en;
    pend_elem_d = cnt_elem;
    pend_last_d = cnt_last_elem;
    pend_tr_d   = cnt_tr;
    pend_tc_d   = cnt_tc;
    cap_last    = rd_pend_q && pend_last_q;
  end

  // Fill/output register pair: returning beats land in the fill word; the
  // finished word goes straight to the output when it is free, else waits.
  always_comb begin
    fill_word = fill_q;
    if (rd_pend_q) begin
      fill_word[pend_elem_q*PIX_W +: PIX_W] = mem_data;
    end
    fill_d      = fill_word;
    fill_full_d = fill_full_q;
    fill_tr_d   = fill_tr_q;
    fill_tc_d   = fill_tc_q;
    out_valid_d = out_valid_q && !accept;
    out_data_d  = out_data_q;
    out_tr_d    = out_tr_q;
    out_tc_d    = out_tc_q;
    if (cap_last) begin
      if (!out_valid_q || accept) begin
        out_valid_d = 1'b1;
        out_data_d  = fill_word;
        out_tr_d    = pend_tr_q;
        out_tc_d    = pend_tc_q;
      end else begin
        fill_full_d = 1'b1;
        fill_tr_d   = pend_tr_q;
        fill_tc_d   = pend_tc_q;
      end
    end else if (fill_full_q && accept) begin
      fill_full_d = 1'b0;
      out_valid_d = 1'b1;
      out_data_d  = fill_q;
      out_tr_d    = fill_tr_q;
      out_tc_d    = fill_tc_q;
    end
  end

  // Frame sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (rd_en && cnt_last_elem && cnt_last_tile) begin
          state_d = S_FLUSH;
        end else if (cap_last && out_valid_q && !accept) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:  if (accept) state_d = S_FETCH;
      S_FLUSH: if (accept && !fill_full_q && !rd_pend_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, in-flight tracking and tile registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      rd_pend_q   <= 1'b0;
      pend_elem_q <= '0;
      pend_last_q <= 1'b0;
      pend_tr_q   <= '0;
      pend_tc_q   <= '0;
      fill_q      <= '0;
      fill_full_q <= 1'b0;
      fill_tr_q   <= '0;
      fill_tc_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tr_q    <= '0;
      out_tc_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      pend_elem_q <= pend_elem_d;
      pend_last_q <= pend_last_d;
      pend_tr_q   <= pend_tr_d;
      pend_tc_q   <= pend_tc_d;
      fill_q      <= fill_d;
      fill_full_q <= fill_full_d;
      fill_tr_q   <= fill_tr_d;
      fill_tc_q   <= fill_tc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tr_q    <= out_tr_d;
      out_tc_q    <= out_tc_d;
    end
  end

  assign mem_addr   = cnt_addr;
  assign mem_rd     = rd_en;
  assign win_valid  = out_valid_q;
  assign win_data   = out_data_q;
  assign win_tile_r = out_tr_q;
  assign win_tile_c = out_tc_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_HOLD) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);

`ifdef SUBMATRIX_DEBUG_EN
  assign dbg_state = state_q;
  assign dbg_elem  = cnt_elem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_submatrix_window_gen.sv
`default_nettype none
// ============================================================================
//  Module : tb_submatrix_window_gen
//  Brief  : Directed bench: 64x64/WIN4/1-bit instance (A) and
//           8x8/WIN2/8-bit instance (B), each fed by a one-cycle ROM model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_submatrix_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default geometry, ROM pixel = address[0]
  logic        a_rst_n, a_start, a_ready, a_rd, a_valid, a_busy, a_done;
  logic [15:0] a_addr, a_data, a_tr, a_tc;
  logic [0:0]  a_rom_q;

  // Instance B: 8x8, WIN=2, 8-bit pixels, ROM data = address[7:0]
  logic        b_rst_n, b_start, b_ready, b_rd, b_valid, b_busy, b_done;
  logic [15:0] b_addr, b_tr, b_tc;
  logic [31:0] b_data;
  logic [7:0]  b_rom_q;

  submatrix_window_gen #(.IMG_W(64), .IMG_H(64), .WIN(4), .PIX_W(1), .ADDR_W(16)) u_dut_a (
    .clock(clk), .resetN(a_rst_n), .start(a_start), .mem_addr(a_addr), .mem_rd(a_rd),
    .mem_data(a_rom_q), .win_valid(a_valid), .win_ready(a_ready), .win_data(a_data),
    .win_tile_r(a_tr), .win_tile_c(a_tc), .busy(a_busy), .done(a_done));

  submatrix_window_gen #(.IMG_W(8), .IMG_H(8), .WIN(2), .PIX_W(8), .ADDR_W(16)) u_dut_b (
    .clock(clk), .resetN(b_rst_n), .start(b_start), .mem_addr(b_addr), .mem_rd(b_rd),
    .mem_data(b_rom_q), .win_valid(b_valid), .win_ready(b_ready), .win_data(b_data),
    .win_tile_r(b_tr), .win_tile_c(b_tc), .busy(b_busy), .done(b_done));

  always @(posedge clk) begin
    a_rom_q <= a_addr[0:0];
    b_rom_q <= b_addr[7:0];
  end

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  int a_rd_n, a_tile_n, a_done_n, a_done_t;
  int b_rd_n, b_tile_n, b_done_n, b_done_t;
  logic [15:0] a_first_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Address of the i-th read of a frame for a given geometry.
  function automatic int exp_addr(input int i, input int imgw, input int win);
    int n, e, tx;
    n  = i / (win*win);
    e  = i % (win*win);
    tx = imgw / win;
    return ((n / tx) * win + e / win) * imgw + (n % tx) * win + e % win;
  endfunction

  function automatic logic [15:0] exp_a_tile(input int n);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[k] = (exp_addr(n*16 + k, 64, 4) % 2) != 0;
    return w;
  endfunction

  function automatic logic [31:0] exp_b_tile(input int n);
    logic [31:0] w;
    int v;
    for (int k = 0; k < 4; k++) begin
      v = exp_addr(n*4 + k, 8, 2);
      w[k*8 +: 8] = 8'(v);
    end
    return w;
  endfunction

  // Per-cycle scoreboard for both instances.
  task automatic sample();
    if (a_rd) begin
      check("a_rd_addr", 64'(a_addr), 64'(exp_addr(a_rd_n, 64, 4)));
      a_rd_n++;
    end
    if (a_valid && a_ready) begin
      if (a_tile_n == 0) a_first_data = a_data;
      check("a_tile_rc", {a_tr, a_tc}, {16'(a_tile_n / 16), 16'(a_tile_n % 16)});
      check("a_tile_data", 64'(a_data), 64'(exp_a_tile(a_tile_n)));
      a_tile_n++;
    end
    if (a_done) begin a_done_n++; a_done_t = t; end
    if (b_rd) begin
      check("b_rd_addr", 64'(b_addr), 64'(exp_addr(b_rd_n, 8, 2)));
      b_rd_n++;
    end
    if (b_valid && b_ready) begin
      check("b_tile_rc", {b_tr, b_tc}, {16'(b_tile_n / 4), 16'(b_tile_n % 4)});
      check("b_tile_data", 64'(b_data), 64'(exp_b_tile(b_tile_n)));
      if (b_tr == 16'd1 && b_tc == 16'd2)
        check("b_tile_1_2", 64'(b_data), 64'h1D1C1514);
      b_tile_n++;
    end
    if (b_done) begin b_done_n++; b_done_t = t; end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic clr_a(); a_rd_n = 0; a_tile_n = 0; a_done_n = 0; a_done_t = -1; endtask
  task automatic clr_b(); b_rd_n = 0; b_tile_n = 0; b_done_n = 0; b_done_t = -1; endtask

  initial begin
    a_rst_n = 0; a_start = 0; a_ready = 0;
    b_rst_n = 0; b_start = 0; b_ready = 0;
    clr_a(); clr_b();
    #1;
    check("a_rst_ctl", {a_rd, a_valid, a_busy, a_done}, 0);
    check("a_rst_dat", {a_addr, a_data, a_tr, a_tc}, 0);
    check("b_rst_ctl", {b_rd, b_valid, b_busy, b_done, b_tc}, 0);
    check("b_rst_dat", {b_addr, b_data, b_tr}, 0);
    @(posedge clk); #1;
    a_rst_n = 1; b_rst_n = 1;
    repeat (3) cyc();

    // ---- A1: free-running frame, stray start mid-frame ----
    clr_a(); a_ready = 1;
    check("a_idle_busy", a_busy, 0);
    a_start = 1; t = 0; cyc(); a_start = 0;
    check("a_first_rd", {a_busy, a_rd, a_addr}, {1'b1, 1'b1, 16'd0});
    while (a_done_n == 0 && t < 6000) begin
      a_start = (t == 100);
      cyc();
    end
    a_start = 0;
    repeat (5) cyc();
    check("a1_done_t", a_done_t, 4099);
    check("a1_done_n", a_done_n, 1);
    check("a1_tiles", a_tile_n, 256);
    check("a1_reads", a_rd_n, 4096);
    check("a1_tile00", a_first_data, 16'hAAAA);
    check("a1_busy_end", a_busy, 0);

    // ---- A2: output stalled for 40 cycles after first win_valid ----
    clr_a(); a_ready = 0;
    a_start = 1; t = 0; cyc(); a_start = 0;
    while (!a_valid && t < 100) cyc();
    check("a2_first_valid_t", t, 18);
    for (int i = 0; i < 40; i++) begin
      check("a2_hold_tile0", {a_valid, a_tr, a_tc, a_data}, {1'b1, 16'd0, 16'd0, 16'hAAAA});
      cyc();
    end
    check("a2_stall_reads", {a_rd, 32'(a_rd_n)}, {1'b0, 32'd32});
    a_ready = 1; #1;
    check("a2_accept_cycle_rd", a_rd, 0);
    cyc();
    check("a2_resume_rd", {a_rd, a_addr}, {1'b1, 16'(exp_addr(32, 64, 4))});
    while (a_done_n == 0 && t < 6000) cyc();
    repeat (3) cyc();
    check("a2_done_t", a_done_t, 4125);
    check("a2_tiles", a_tile_n, 256);
    check("a2_reads", a_rd_n, 4096);
    check("a2_done_n", a_done_n, 1);

    // ---- B1: free-running small frame ----
    clr_b(); b_ready = 1;
    b_start = 1; t = 0; cyc(); b_start = 0;
    while (b_done_n == 0 && t < 500) cyc();
    repeat (3) cyc();
    check("b1_done_t", b_done_t, 67);
    check("b1_tiles", b_tile_n, 16);
    check("b1_reads", b_rd_n, 64);

    // ---- B2: ready pulse in the cycle tile 1 completes, then a hold ----
    clr_b(); b_ready = 0;
    b_start = 1; t = 0; cyc(); b_start = 0;
    while (t < 9) cyc();
    b_ready = 1; #1;
    check("b2_pulse_rd", {b_rd, b_addr, 32'(b_rd_n)}, {1'b1, 16'd4, 32'd8});
    cyc();
    b_ready = 0;
    check("b2_direct_load", {b_valid, b_tr, b_tc, 32'(b_rd_n)}, {1'b1, 16'd0, 16'd1, 32'd9});
    check("b2_direct_data", 64'(b_data), 64'(exp_b_tile(1)));
    while (t < 14) cyc();
    check("b2_hold", {b_rd, b_tc, 32'(b_rd_n)}, {1'b0, 16'd1, 32'd12});
    b_ready = 1;
    while (b_done_n == 0 && t < 500) cyc();
    repeat (3) cyc();
    check("b2_done_t", b_done_t, 69);
    check("b2_tiles", b_tile_n, 16);
    check("b2_reads", b_rd_n, 64);

    // ---- B3: reset mid tile 3, then a fresh frame ----
    clr_b(); b_ready = 1;
    b_start = 1; t = 0; cyc(); b_start = 0;
    while (b_rd_n < 14 && t < 100) cyc();
    b_rst_n = 0; #1;
    check("b3_rst_ctl", {b_rd, b_valid, b_busy, b_done, b_tc}, 0);
    check("b3_rst_dat", {b_addr, b_data, b_tr}, 0);
    cyc(); cyc();
    b_rst_n = 1;
    cyc(); cyc();
    check("b3_idle", {b_busy, b_valid, b_rd}, 0);
    clr_b();
    b_start = 1; t = 0; cyc(); b_start = 0;
    check("b3_restart_rd", {b_rd, b_addr}, {1'b1, 16'd0});
    while (b_done_n == 0 && t < 500) cyc();
    repeat (3) cyc();
    check("b3_done_t", b_done_t, 67);
    check("b3_tiles", b_tile_n, 16);
    check("b3_done_n", b_done_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0d)", t);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/submatrix_window_gen.md
# submatrix_window_gen

Parametrised successor to the fixed 16-element submatrix generator. It walks a row-major image held in a synchronous one-cycle-latency ROM and issues one read per cycle, with the address computed from tile/row/column counters. It packs each non-overlapping WIN×WIN tile into one word and hands tiles downstream over a valid/ready handshake. A fill register and an output register let the next tile be fetched while the current one waits to be accepted.

## Interface
- IMG_W, 64: image width in pixels; multiple of WIN
- IMG_H, 64: image height in pixels; multiple of WIN
- WIN, 4: tile edge; tile holds WIN*WIN elements
- PIX_W, 1: bits per pixel
- ADDR_W, 16: ROM address width; IMG_W*IMG_H ≤ 2^ADDR_W
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- mem_addr  out  ADDR_W  ROM address
- mem_rd  out  1  read issued this cycle
- mem_data  in  PIX_W  ROM q, valid the cycle after mem_rd
- win_valid  out  1  win_data holds a complete tile
- win_ready  in  1  downstream accepts the tile
- win_data  out  WIN*WIN*PIX_W  packed tile; element k=r*WIN+c at bits [k*PIX_W +: PIX_W]
- win_tile_r, win_tile_c  out  ADDR_W  tile coordinates of win_data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final tile is accepted

## Operation
- Reset: all outputs 0, FSM in IDLE, counters cleared, both registers empty.
- FSM states:
  - IDLE: start → FETCH.
  - FETCH: one read per cycle.
  - HOLD: fill register complete, output register occupied, reads paused.
  - FLUSH: all reads issued; waiting for the last tile to be accepted.
  - DONE: one cycle; done=1; then → IDLE.
- Tile order: tile rows top-to-bottom; within a row, tiles left-to-right.
- Element order within a tile: row-major.
- Address: (tr*WIN+r)*IMG_W + tc*WIN + c. Computed in ADDR_W bits with no wrap, guaranteed by the parameter rule.
- The in-flight read is tracked by a one-cycle delayed mem_rd. Each returning element is written into the fill register at its slot k.
- The edge that captures element WIN*WIN−1:
  - If the output register is empty, or win_valid&win_ready this cycle, the completed word (including the final element) loads the output register directly, together with its tile coordinates.
  - Otherwise the fill register holds it → HOLD.
- The first read of a new tile is issued only if (!win_valid || win_ready) in that cycle. This is a deliberate combinational path from win_ready to mem_rd.
- HOLD exit: win_ready while win_valid → fill moves to output on that edge; the first read of the next tile is issued the next cycle.
- win_valid stays high and win_data stays stable until accepted. win_ready while win_valid=0 is ignored.
- start in any state other than IDLE is ignored.
- resetN low mid-frame: immediate return to IDLE. A mem_data beat returning after reset is discarded.
- Illegal parameters (IMG_W or IMG_H not a multiple of WIN, or the image overflowing ADDR_W) are rejected at elaboration.

## Timing
- Start sampled at edge 0; first mem_rd in cycle 1 with mem_addr=0.
- With win_ready held 1:
  - Reads are continuous, with no bubbles between tiles.
  - Tile n's last read is in cycle (n+1)*WIN*WIN.
  - win_valid for tile n rises 2 cycles after its last read.
- Throughput: one tile per WIN*WIN cycles.
- Frame: (IMG_W/WIN)*(IMG_H/WIN) tiles. busy rises the cycle after start and falls with done.
- Stall recovery: the first read resumes one cycle after the accepting edge.

## Configuration
- SUBMATRIX_DEBUG_EN defined: adds the ports dbg_state (3 bits, FSM encoding) and dbg_elem (log2(WIN*WIN) bits, current fill slot). Functional behaviour is unchanged.
- SUBMATRIX_DEBUG_EN undefined: these ports and their logic are absent.

## Structure
- Shared package submatrix_pkg holds:
  - the FSM state enum: IDLE=0, FETCH=1, HOLD=2, FLUSH=3, DONE=4;
  - a clog2-style width helper function.
- One sub-module: tile_addr_counter, holding the nested tr/tc/r/c counters, address generation, last-element and last-tile flags, and an advance enable.
- The fill/output register pair and the FSM live in the top module.

## Test plan
- Defaults, ROM loaded with pixel=address[0], win_ready=1: 256 tiles. Tile (0,0) win_data=16'hAAAA. done pulses exactly once, 4099 cycles after start.
- IMG_W=8, IMG_H=8, WIN=2, PIX_W=8, ROM data = address[7:0]. Tile (1,2) win_data={8'd29,8'd28,8'd21,8'd20}.
- win_ready held 0 for 40 cycles after the first win_valid:
  - mem_rd stops after the 32nd read and the FSM is in HOLD;
  - tile 0 data stays stable;
  - after release, tiles arrive in order with no missing or duplicated address.
- win_ready pulsed in the same cycle tile 1's last element returns: tile 1 loads the output register directly and the read stream shows no bubble.
- resetN dropped mid-tile 3, then start reasserted: all outputs are 0 during reset; the new frame begins at mem_addr=0, and tile 0 matches the first run.
- start pulsed while busy: ignored; tile count and done timing are unchanged.
